// File: rtl/reorder_logic_defines.sv
`default_nettype none
// ============================================================================
// reorder_logic_defines: widths and helpers shared by the re-order issuer and selector
// Rev 1.0
// ============================================================================
package reorder_logic_defines;

  localparam int NUM_QUEUES_DEF = 4;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Modulo-n increment for round-robin pointers.
  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_logic_credit_cnt.sv
`default_nettype none
// ============================================================================
// reorder_logic_credit_cnt: per-queue saturating up/down outstanding-entry counter
// Rev 1.0
// ============================================================================
module reorder_logic_credit_cnt
  import reorder_logic_defines::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_WIDTH = clog2(DEPTH + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  logic [CNT_WIDTH-1:0] r_cnt;

  assign o_full  = (r_cnt == CNT_WIDTH'(DEPTH));
  assign o_empty = (r_cnt == '0);

  // Simultaneous inc and dec cancel out; saturation guards protect the range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_logic_tag_issuer.sv
`default_nettype none
// ============================================================================
// reorder_logic_tag_issuer: round-robin tag issue with per-queue credits and retire pointer
// Rev 1.0
// ============================================================================
module reorder_logic_tag_issuer
  import reorder_logic_defines::*;
#(
  parameter int NUM_QUEUES  = NUM_QUEUES_DEF,
  parameter int QUEUE_DEPTH = 4,
  localparam int SEL_WIDTH  = clog2(NUM_QUEUES),
  localparam int CNT_WIDTH  = clog2(QUEUE_DEPTH + 1),
  localparam int TOT_WIDTH  = SEL_WIDTH + CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [SEL_WIDTH-1:0]  req_tag_o,
  output logic                  next_valid_o,
  output logic [SEL_WIDTH-1:0]  next_o,
  input  logic [NUM_QUEUES-1:0] ack_i,
  output logic [TOT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  logic [SEL_WIDTH-1:0]  r_issue_ptr;
  logic [SEL_WIDTH-1:0]  r_retire_ptr;
  logic [TOT_WIDTH-1:0]  r_total;
  logic                  r_err;

  logic [NUM_QUEUES-1:0] w_full;
  logic [NUM_QUEUES-1:0] w_empty;
  logic [NUM_QUEUES-1:0] w_inc;
  logic [NUM_QUEUES-1:0] w_dec;
  logic                  w_issue;
  logic                  w_onehot;
  logic                  w_retire;
  logic                  w_ack_err;

  assign req_tag_o     = r_issue_ptr;
  assign next_o        = r_retire_ptr;
  assign req_ready_o   = !w_full[r_issue_ptr];
  assign next_valid_o  = !w_empty[r_retire_ptr];
  assign outstanding_o = r_total;
  assign err_o         = r_err;

  assign w_issue  = req_valid_i && req_ready_o;
  assign w_onehot = (ack_i != '0) && ((ack_i & (ack_i - NUM_QUEUES'(1))) == '0);
  // Only a lone ack on the retire queue with something outstanding counts.
  assign w_retire  = w_onehot && ack_i[r_retire_ptr] && next_valid_o;
  assign w_ack_err = (ack_i != '0) && !w_retire;

  generate
    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_credit
      assign w_inc[g] = w_issue  && (r_issue_ptr  == SEL_WIDTH'(g));
      assign w_dec[g] = w_retire && (r_retire_ptr == SEL_WIDTH'(g));

      reorder_logic_credit_cnt #(
        .DEPTH (QUEUE_DEPTH)
      ) u_credit_cnt (
        .i_clk   (clk_i),
        .i_rst_n (arst_n_i),
        .i_inc   (w_inc[g]),
        .i_dec   (w_dec[g]),
        .o_full  (w_full[g]),
        .o_empty (w_empty[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_issue_ptr  <= '0;
      r_retire_ptr <= '0;
      r_total      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_issue) begin
        r_issue_ptr <= SEL_WIDTH'(wrap_inc(int'(r_issue_ptr), NUM_QUEUES));
      end
      if (w_retire) begin
        r_retire_ptr <= SEL_WIDTH'(wrap_inc(int'(r_retire_ptr), NUM_QUEUES));
      end
      r_total <= r_total + TOT_WIDTH'(w_issue) - TOT_WIDTH'(w_retire);
      if (w_ack_err) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_logic_tag_issuer.sv
`default_nettype none
// ============================================================================
// tb_reorder_logic_tag_issuer: vector table, corner sequences and randomized model check
// Rev 1.0
// ============================================================================
module tb_reorder_logic_tag_issuer;

  localparam int N = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       arst_n_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic [3:0] ack_i = '0;
  logic       req_ready_o;
  logic [1:0] req_tag_o;
  logic       next_valid_o;
  logic [1:0] next_o;
  logic [3:0] outstanding_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;

  int mcnt [N];
  int mip;
  int mrp;
  bit merr;

  typedef struct {
    logic       v;
    logic [3:0] ack;
    int         tag;
    logic       rdy;
    int         nxt;
    logic       nv;
    int         outs;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  reorder_logic_tag_issuer #(
    .NUM_QUEUES  (N),
    .QUEUE_DEPTH (D)
  ) dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_tag_o     (req_tag_o),
    .next_valid_o  (next_valid_o),
    .next_o        (next_o),
    .ack_i         (ack_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int msum();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += mcnt[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mip  = 0;
    mrp  = 0;
    merr = 1'b0;
  endtask

  // Applies one clock of the issue/retire rules to the reference state.
  task automatic model_step();
    bit         iss;
    bit         ret;
    logic [3:0] want;
    want = 4'(1 << mrp);
    iss  = req_valid_i && (mcnt[mip] < D);
    ret  = (ack_i == want) && (mcnt[mrp] > 0);
    if (ack_i != 4'b0000 && !ret) merr = 1'b1;
    if (iss) begin
      mcnt[mip]++;
      mip = (mip + 1) % N;
    end
    if (ret) begin
      mcnt[mrp]--;
      mrp = (mrp + 1) % N;
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".tag"},   32'(req_tag_o),     32'(mip));
    chk({nm, ".ready"}, 32'(req_ready_o),   32'(mcnt[mip] != D));
    chk({nm, ".next"},  32'(next_o),        32'(mrp));
    chk({nm, ".nvld"},  32'(next_valid_o),  32'(mcnt[mrp] != 0));
    chk({nm, ".outs"},  32'(outstanding_o), 32'(msum()));
    chk({nm, ".err"},   32'(err_o),         32'(merr));
  endtask

  task automatic set_in(input logic v, input logic [3:0] a);
    req_valid_i = v;
    ack_i       = a;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear without any clock edge.
  task automatic do_reset(input string nm);
    arst_n_i = 1'b0;
    #1;
    model_reset();
    chk({nm, ".rdy1"},  32'(req_ready_o),   32'd1);
    chk({nm, ".nv0"},   32'(next_valid_o),  32'd0);
    chk({nm, ".tag0"},  32'(req_tag_o),     32'd0);
    chk({nm, ".next0"}, 32'(next_o),        32'd0);
    chk({nm, ".outs0"}, 32'(outstanding_o), 32'd0);
    chk({nm, ".err0"},  32'(err_o),         32'd0);
    req_valid_i = 1'b0;
    ack_i       = '0;
    @(negedge clk);
    arst_n_i = 1'b1;
  endtask

  initial begin
    //          v     ack      tag rdy   nxt nv    outs err
    tbl[0] = '{1'b1, 4'b0000, 0, 1'b1, 0, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 1, 1'b1, 0, 1'b1, 1, 1'b0};
    tbl[2] = '{1'b1, 4'b0000, 2, 1'b1, 0, 1'b1, 2, 1'b0};
    tbl[3] = '{1'b1, 4'b0000, 3, 1'b1, 0, 1'b1, 3, 1'b0};
    tbl[4] = '{1'b1, 4'b0000, 0, 1'b1, 0, 1'b1, 4, 1'b0};
    tbl[5] = '{1'b1, 4'b0000, 1, 1'b1, 0, 1'b1, 5, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, 2, 1'b1, 0, 1'b1, 6, 1'b0};
    tbl[7] = '{1'b0, 4'b0001, 2, 1'b1, 0, 1'b1, 6, 1'b0};
    tbl[8] = '{1'b0, 4'b0010, 2, 1'b1, 1, 1'b1, 5, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 2, 1'b1, 2, 1'b1, 4, 1'b0};

    model_reset();
    @(negedge clk);
    do_reset("init");

    // Idle after reset, then issue six and retire two in order.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].ack);
      chk($sformatf("vec%0d.tag", i),   32'(req_tag_o),     32'(tbl[i].tag));
      chk($sformatf("vec%0d.ready", i), 32'(req_ready_o),   32'(tbl[i].rdy));
      chk($sformatf("vec%0d.next", i),  32'(next_o),        32'(tbl[i].nxt));
      chk($sformatf("vec%0d.nvld", i),  32'(next_valid_o),  32'(tbl[i].nv));
      chk($sformatf("vec%0d.outs", i),  32'(outstanding_o), 32'(tbl[i].outs));
      chk($sformatf("vec%0d.err", i),   32'(err_o),         32'(tbl[i].err));
      tick();
    end

    set_in(1'b1, 4'b0000);
    tick();
    chk_model("midtraffic");
    do_reset("midrst");

    // Fill every queue, stall with tag 0 pending, then reopen by retiring queue 0.
    for (int i = 0; i < N * D; i++) begin
      set_in(1'b1, 4'b0000);
      chk("fill.tag", 32'(req_tag_o), 32'(i % N));
      tick();
    end
    set_in(1'b1, 4'b0000);
    chk("full.ready", 32'(req_ready_o), 32'd0);
    chk("full.tag", 32'(req_tag_o), 32'd0);
    chk("full.outs", 32'(outstanding_o), 32'(N * D));
    tick();
    chk("stall.tag", 32'(req_tag_o), 32'd0);
    chk("stall.ready", 32'(req_ready_o), 32'd0);
    set_in(1'b1, 4'b0001);
    chk("ackcyc.ready", 32'(req_ready_o), 32'd0);
    tick();
    set_in(1'b1, 4'b0000);
    chk("reopen.ready", 32'(req_ready_o), 32'd1);
    chk("reopen.tag", 32'(req_tag_o), 32'd0);
    chk("reopen.outs", 32'(outstanding_o), 32'(N * D - 1));
    tick();
    chk("reissue.tag", 32'(req_tag_o), 32'd1);
    chk("reissue.outs", 32'(outstanding_o), 32'(N * D));
    chk_model("fillseq");
    do_reset("rst2");

    // Simultaneous issue and retire on queue 0 with every queue at one.
    for (int i = 0; i < N; i++) begin
      set_in(1'b1, 4'b0000);
      tick();
    end
    set_in(1'b1, 4'b0001);
    tick();
    set_in(1'b0, 4'b0000);
    chk("simul.tag", 32'(req_tag_o), 32'd1);
    chk("simul.next", 32'(next_o), 32'd1);
    chk("simul.outs", 32'(outstanding_o), 32'd4);
    for (int i = 1; i < N; i++) begin
      set_in(1'b0, 4'(1 << i));
      tick();
    end
    set_in(1'b0, 4'b0000);
    chk("simul.cnt0.next", 32'(next_o), 32'd0);
    chk("simul.cnt0.nvld", 32'(next_valid_o), 32'd1);
    chk("simul.cnt0.outs", 32'(outstanding_o), 32'd1);
    do_reset("rst3");

    // Protocol errors leave state untouched and latch err_o.
    set_in(1'b0, 4'b0001);
    tick();
    set_in(1'b0, 4'b0000);
    chk("err.empty.err", 32'(err_o), 32'd1);
    chk("err.empty.outs", 32'(outstanding_o), 32'd0);
    chk("err.empty.next", 32'(next_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'b0000);
      tick();
    end
    set_in(1'b0, 4'b0100);
    tick();
    set_in(1'b0, 4'b0011);
    tick();
    set_in(1'b0, 4'b0000);
    chk("err.bad.next", 32'(next_o), 32'd0);
    chk("err.bad.outs", 32'(outstanding_o), 32'd3);
    chk("err.bad.tag", 32'(req_tag_o), 32'd3);
    set_in(1'b0, 4'b0001);
    tick();
    set_in(1'b0, 4'b0000);
    chk("err.sticky", 32'(err_o), 32'd1);
    chk("err.legal.next", 32'(next_o), 32'd1);
    chk("err.legal.outs", 32'(outstanding_o), 32'd2);
    do_reset("rst4");

    // Random traffic: legal acks only, then with occasional garbage acks.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 300; i++) begin
        logic       v;
        logic [3:0] a;
        int         r;
        v = ($urandom % 4) != 0;
        r = $urandom % 16;
        a = (r < 7 && mcnt[mrp] > 0) ? 4'(1 << mrp) : 4'b0000;
        if (phase == 1 && r == 7) a = 4'($urandom % 16);
        set_in(v, a);
        chk_model($sformatf("rand%0d", phase));
        tick();
      end
      set_in(1'b0, 4'b0000);
      chk_model("randend");
      do_reset("rst5");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_logic_tag_issuer.md
Name: reorder_logic_tag_issuer

Overview:
Issue-side companion of the re-order selector. Stamps each outgoing request with an in-order queue tag, round-robin over NUM_QUEUES. It tracks outstanding entries per queue with credit counters and back-pressures the requester when the target queue is full. It owns the retire pointer and drives the selector's valid/next inputs, advancing on the selector's pull-acknowledge.

Parameters:
NUM_QUEUES, 4, number of re-order queues; legal range 2..256, power of two not required.
QUEUE_DEPTH, 4, maximum outstanding entries per queue; legal range 1..255.
SEL_WIDTH, localparam = clog2(NUM_QUEUES), tag / pointer width.
CNT_WIDTH, localparam = clog2(QUEUE_DEPTH+1), per-queue credit counter width.

Ports:
clk_i  input  1  system clock, rising edge.
arst_n_i  input  1  reset, asynchronous, active-low.
req_valid_i  input  1  requester has a request to issue.
req_ready_o  output  1  issuer can accept; a request is issued when req_valid_i & req_ready_o.
req_tag_o  output  SEL_WIDTH  queue tag for the current request; stable while req_valid_i & !req_ready_o.
next_valid_o  output  1  retire queue has at least one outstanding entry (to selector valid_i).
next_o  output  SEL_WIDTH  retire pointer, next expected queue (to selector next_i).
ack_i  input  NUM_QUEUES  pull-acknowledge from selector (its ack_o); at most one bit per cycle.
outstanding_o  output  SEL_WIDTH+CNT_WIDTH  total outstanding entries across all queues.
err_o  output  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - issue_ptr = 0, retire_ptr = 0.
  - All credit counters = 0, total = 0, err_o = 0.
  - Resulting outputs: req_ready_o = 1, next_valid_o = 0, req_tag_o = 0, next_o = 0, outstanding_o = 0.
  - Reset mid-operation discards all tracking immediately. No drain.
- Combinational outputs:
  - req_tag_o = issue_ptr.
  - req_ready_o = (cnt[issue_ptr] != QUEUE_DEPTH).
  - next_o = retire_ptr.
  - next_valid_o = (cnt[retire_ptr] != 0).
- Issue (req_valid_i & req_ready_o):
  - cnt[issue_ptr] += 1.
  - issue_ptr wraps NUM_QUEUES-1 -> 0, else +1.
  - Zero-latency handshake; the tag is consumed in the same cycle.
- Retire (ack_i[retire_ptr] = 1, ack_i one-hot, next_valid_o = 1):
  - cnt[retire_ptr] -= 1.
  - retire_ptr wraps NUM_QUEUES-1 -> 0, else +1.
  - The new next_o is visible the cycle after the ack.
- Simultaneous issue and retire on the same queue: counter unchanged, both pointers advance. Issue and retire on different queues update independently.
- Total counter: +1 on issue, -1 on retire, net 0 when both occur in one cycle.
- Protocol errors. Each sets err_o = 1 (sticky until reset) and the offending ack has no effect on state:
  - ack_i not one-hot.
  - Ack bit set for a queue other than retire_ptr.
  - Ack while next_valid_o = 0.
  - A legal issue in the same cycle still proceeds.
- Full: with all queues at QUEUE_DEPTH, total = NUM_QUEUES*QUEUE_DEPTH and req_ready_o = 0. The first retire to the blocked queue reopens req_ready_o the next cycle.
- Empty: next_valid_o = 0. ack_i is expected to be 0, since the selector gates ack with valid_i.
- No combinational path from ack_i to req_ready_o or next_valid_o; those depend only on registered state.

Decomposition:
- Shared package/include (reorder_logic_defines): NUM_QUEUES default, clog2 function, SEL_WIDTH derivation, and a wrap-increment macro/function, all shared with reorder_logic_selector.
- One natural sub-module: reorder_logic_credit_cnt, a single per-queue up/down saturating counter with inc/dec/full/empty. Instantiate it NUM_QUEUES times in a generate loop.
- Pointer and error logic stays in the top.

Test Plan:
1. Reset then idle: check req_ready_o = 1, next_valid_o = 0, next_o = 0, outstanding_o = 0, err_o = 0. Assert arst_n_i low mid-traffic and check all outputs return to these values in the same cycle, without a clock edge.
2. Issue 6 requests, NUM_QUEUES = 4, no acks: req_tag_o sequence is 0,1,2,3,0,1; outstanding_o = 6; next_valid_o = 1, next_o = 0.
3. Retire in order: from scenario 2, pulse ack_i = 4'b0001, then 4'b0010. next_o goes 0 -> 1 -> 2 and outstanding_o goes 6 -> 5 -> 4.
4. Fill with QUEUE_DEPTH = 2, 8 issues: req_ready_o = 0 with tag 0 pending and no tag change while stalled. Ack 4'b0001 and check req_ready_o = 1 the next cycle; the stalled request issues with tag 0.
5. Simultaneous issue and retire of queue 0, each queue at cnt = 1: cnt[0] stays 1, issue_ptr = 1, retire_ptr = 1, outstanding_o unchanged.
6. Protocol errors. Each leaves the pointers and counts unchanged and sets err_o = 1, which stays 1 until reset:
   - ack_i = 4'b0100 while next_o = 0.
   - ack_i = 4'b0011.
   - ack_i = 4'b0001 with zero outstanding.
